// File: rtl/w_rom_burner_pkg.sv
// w_rom_burner_pkg
//   Shared definitions for the ROM burn-in blocks: FSM state encoding and
//   sizing helpers for beat count and address width.
package w_rom_burner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of input beats needed to cover one word (rounded up).
  function automatic int calc_beats(input int data_width, input int in_width);
    return (data_width + in_width - 1) / in_width;
  endfunction

  // Counter/address width; never narrower than 1 bit so a depth of 1 still
  // yields a legal vector.
  function automatic int calc_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/w_rom_beat_packer.sv
// w_rom_beat_packer
//   Beat counter plus assembly register. Beats land LSB-first; bits of the
//   final beat that fall beyond DATA_WIDTH are kept only in the padded
//   register and never reach word_next.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           restart assembly (count and register to zero)
//   beat_en         a beat is accepted this cycle
//   s_data          incoming beat
//   word_next       assembled word including this cycle's beat
//   word_done       this cycle's beat completes the word
module w_rom_beat_packer
  import w_rom_burner_pkg::*;
#(
  parameter int DATA_WIDTH = 4608,
  parameter int IN_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  beat_en,
  input  logic [IN_WIDTH-1:0]   s_data,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_done
);

  localparam int BEATS = calc_beats(DATA_WIDTH, IN_WIDTH);
  localparam int CNT_W = calc_addr_width(BEATS);
  localparam int PAD_W = BEATS * IN_WIDTH;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PAD_W-1:0] asm_q, asm_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    asm_d      = asm_q;
    word_done  = 1'b0;
    if (clear) begin
      beat_cnt_d = '0;
      asm_d      = '0;
    end else if (beat_en) begin
      // Constant-offset slices selected by the count keep the insert a
      // simple per-slot mux.
      for (int b = 0; b < BEATS; b++) begin
        if (beat_cnt_q == CNT_W'(b)) asm_d[b*IN_WIDTH +: IN_WIDTH] = s_data;
      end
      if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
        word_done  = 1'b1;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  assign word_next = asm_d[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      asm_q      <= asm_d;
    end
  end

endmodule

// File: rtl/w_rom_burner.sv
// w_rom_burner
//   Collects IN_WIDTH beats into DATA_WIDTH words and writes DATA_DEPTH
//   words to a ROM, one write strobe per word, while burn_in_en is held.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   burn_in_en               level request; dropping it aborts the sequence
//   s_data/s_valid/s_ready   beat stream (LSB-first within a word)
//   wr_en/wr_addr/wr_data    ROM write port (address/data held between writes)
//   burned                   all words written; sticky until reset
//   busy                     sequence in progress
//   cksum                    running XOR of accepted beats
// Optional feature: define W_ROM_BURNER_CKSUM_EN to build the checksum
// register; otherwise cksum is tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for burn_in_en
// ST_LOAD  | accepting beats of the current word
// ST_WRITE | one-cycle ROM write of the assembled word
// ST_DONE  | all words written; holds until reset
module w_rom_burner
  import w_rom_burner_pkg::*;
#(
  parameter int DATA_WIDTH = 4608,
  parameter int DATA_DEPTH = 512,
  parameter int IN_WIDTH   = 32,
  localparam int ADDR_WIDTH = calc_addr_width(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  burn_in_en,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  burned,
  output logic                  busy,
  output logic [IN_WIDTH-1:0]   cksum
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  beat_en;
  logic                  pk_clear;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word_next;

  // A beat arriving in the abort cycle is not consumed into the word.
  assign s_ready  = (state_q == ST_LOAD) && !rst;
  assign beat_en  = s_ready && s_valid && burn_in_en;
  assign pk_clear = (state_q == ST_IDLE) && burn_in_en;
  assign wr_en    = (state_q == ST_WRITE) && burn_in_en && !rst;
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign burned   = (state_q == ST_DONE);
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  w_rom_beat_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (IN_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .beat_en   (beat_en),
    .s_data    (s_data),
    .word_next (word_next),
    .word_done (word_done)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (burn_in_en) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (!burn_in_en) begin
          state_d = ST_IDLE;
        end else if (beat_en && word_done) begin
          // Capture address and word on entry to WRITE so both stay stable
          // until the next word completes.
          state_d   = ST_WRITE;
          wr_addr_d = word_cnt_q;
          wr_data_d = word_next;
        end
      end
      ST_WRITE: begin
        if (!burn_in_en) begin
          state_d = ST_IDLE;
        end else if (word_cnt_q == ADDR_WIDTH'(DATA_DEPTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_LOAD;
          word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

`ifdef W_ROM_BURNER_CKSUM_EN
  logic [IN_WIDTH-1:0] cksum_q, cksum_d;

  // beat_en is never set in ST_DONE, so the value freezes there.
  always_comb begin
    cksum_d = cksum_q;
    if (pk_clear) cksum_d = '0;
    else if (beat_en) cksum_d = cksum_q ^ s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_w_rom_burner.sv
module tb_w_rom_burner;

  localparam int DW = 96;
  localparam int IW = 32;
  localparam int DD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, burn_in_en, s_valid;
  logic [IW-1:0] s_data;

  logic          s_ready, wr_en, burned, busy;
  logic [1:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [IW-1:0] cksum;

  logic          s_ready_80, wr_en_80, burned_80, busy_80;
  logic [1:0]    wr_addr_80;
  logic [79:0]   wr_data_80;
  logic [IW-1:0] cksum_80;

  w_rom_burner #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .IN_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .burn_in_en(burn_in_en), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .burned(burned), .busy(busy), .cksum(cksum)
  );

  // 80-bit words still need 3 beats; shares all stimulus with dut.
  w_rom_burner #(.DATA_WIDTH(80), .DATA_DEPTH(DD), .IN_WIDTH(IW)) dut80 (
    .clk(clk), .rst(rst), .burn_in_en(burn_in_en), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready_80), .wr_en(wr_en_80), .wr_addr(wr_addr_80),
    .wr_data(wr_data_80), .burned(burned_80), .busy(busy_80), .cksum(cksum_80)
  );

  typedef struct {
    int          e;
    logic [1:0]  a;
    logic [95:0] d;
  } wr_t;

  wr_t wq[$];
  wr_t wq80[$];
  int  edge_n = 0;
  int  checks = 0;
  int  errors = 0;

  logic [IW-1:0] beats[0:11];
  int            hs_e[0:11];

  always @(posedge clk) begin
    edge_n++;
    if (wr_en)    wq.push_back('{edge_n, wr_addr, wr_data});
    if (wr_en_80) wq80.push_back('{edge_n, wr_addr_80, {16'h0, wr_data_80}});
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] exp_cksum(input int n);
    logic [IW-1:0] x = '0;
`ifdef W_ROM_BURNER_CKSUM_EN
    for (int i = 0; i < n; i++) x = x ^ beats[i];
`endif
    return x;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_wr_en"},   wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_burned"},  burned, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_cksum"},   cksum, 0);
    chk({tag, "_wr_data80"}, wr_data_80, 0);
    chk({tag, "_burned80"},  burned_80, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; burn_in_en = 1'b0; s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete(); wq80.delete();
  endtask

  task automatic rand_beats();
    for (int i = 0; i < 12; i++) beats[i] = $urandom;
    beats[2] = beats[2] | 32'hFFFF_0000;  // exercise the discarded bits of the 80-bit build
  endtask

  // mode 0: valid every cycle, 1: alternating, 2: random
  task automatic drive(input int n, input int mode);
    int   idx = 0;
    int   guard = 0;
    int   ph = 0;
    logic v;
    while (idx < n && guard < 400) begin
      @(negedge clk);
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (ph % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph++;
      s_valid = v;
      s_data  = v ? beats[idx] : $urandom;
      #1;
      if (v && s_ready) begin
        hs_e[idx] = edge_n + 1;
        idx++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("drive_beats_accepted", idx, n);
  endtask

  task automatic check_writes(input int nw, input string tag);
    logic [95:0] exp;
    logic [1:0]  ra;
    logic [95:0] rd;
    int          re;
    chk({tag, "_nwrites"},   wq.size(), nw);
    chk({tag, "_nwrites80"}, wq80.size(), nw);
    for (int k = 0; k < nw; k++) begin
      exp = {beats[3*k+2], beats[3*k+1], beats[3*k]};
      if (k < wq.size()) begin ra = wq[k].a; rd = wq[k].d; re = wq[k].e; end
      else begin ra = 'x; rd = 'x; re = -1; end
      chk({tag, "_addr"}, ra, k);
      chk({tag, "_data"}, rd, exp);
      chk({tag, "_latency"}, re, hs_e[3*k+2] + 1);
      if (k < wq80.size()) begin ra = wq80[k].a; rd = wq80[k].d; end
      else begin ra = 'x; rd = 'x; end
      chk({tag, "_addr80"}, ra, k);
      chk({tag, "_data80"}, rd, {16'h0, exp[79:0]});
    end
    wq.delete(); wq80.delete();
  endtask

  initial begin
    logic [95:0] w0;
    rst = 1'b1; burn_in_en = 1'b0; s_valid = 1'b0; s_data = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // beats 0x1..0xC, continuous valid
    for (int i = 0; i < 12; i++) beats[i] = 32'(i + 1);
    @(negedge clk);
    burn_in_en = 1'b1;
    drive(12, 0);
    repeat (3) @(negedge clk);
    w0 = (wq.size() > 0) ? wq[0].d : 'x;
    chk("word0_value", w0, 96'h00000003_00000002_00000001);
    check_writes(4, "cont");
    chk("cont_burned", burned, 1);
    chk("cont_busy", busy, 0);
    chk("cont_s_ready", s_ready, 0);
    chk("cont_hold_addr", wr_addr, 3);
    chk("cont_hold_data", wr_data, {beats[11], beats[10], beats[9]});
    chk("cont_cksum", cksum, exp_cksum(12));
    chk("cont_burned80", burned_80, 1);

    // DONE ignores burn_in_en
    burn_in_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_hold_burned", burned, 1);
    burn_in_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_no_writes", wq.size(), 0);
    chk("done_s_ready", s_ready, 0);
    chk("done_cksum_frozen", cksum, exp_cksum(12));

    // alternating then random valid, random data
    for (int m = 1; m <= 2; m++) begin
      do_reset();
      rand_beats();
      burn_in_en = 1'b1;
      drive(12, m);
      repeat (3) @(negedge clk);
      check_writes(4, (m == 1) ? "toggle" : "rndvalid");
      chk("seq_burned", burned, 1);
      chk("seq_cksum", cksum, exp_cksum(12));
      chk("seq_cksum80", cksum_80, exp_cksum(12));
    end

    // abort after 5 beats, then restart
    do_reset();
    rand_beats();
    burn_in_en = 1'b1;
    drive(5, 0);
    burn_in_en = 1'b0;
    repeat (3) @(negedge clk);
    check_writes(1, "abort");
    chk("abort_burned", burned, 0);
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 0);
    rand_beats();
    burn_in_en = 1'b1;
    drive(12, 2);
    repeat (3) @(negedge clk);
    check_writes(4, "restart");
    chk("restart_burned", burned, 1);
    chk("restart_cksum", cksum, exp_cksum(12));

    // reset during the WRITE of address 2
    do_reset();
    rand_beats();
    burn_in_en = 1'b1;
    drive(9, 0);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_write_wr_en", wr_en, 0);
    chk("rst_write_wr_en80", wr_en_80, 0);
    @(negedge clk);
    chk_reset("rst_write");
    rst = 1'b0;
    burn_in_en = 1'b0;
    @(negedge clk);
    check_writes(2, "rst_write");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
